// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: operation codes and FSM states.
package alu_pkg;

   // Operation codes carried on the 3-bit fxn input
   typedef enum logic [2:0] {
      FxnAdd = 3'd0,
      FxnSub = 3'd1,
      FxnAnd = 3'd2,
      FxnOr  = 3'd3,
      FxnXor = 3'd4,
      FxnSlt = 3'd5,
      FxnMul = 3'd6,
      FxnAcc = 3'd7
   } fxn_e;

   // Control FSM states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier. Operands are loaded on start,
// followed by exactly WIDTH add/shift steps. done is high during the cycle of
// the final step and product then shows the completed 2*WIDTH-bit result.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic                 busy_q;
   logic [CntW-1:0]      cnt_q;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic [2*WIDTH-1:0]   prod_d;

   // Partial-product accumulation for the current step
   always_comb begin
      prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
      done    = busy_q && (cnt_q == CntW'(WIDTH - 1));
      product = prod_d;
   end

   // Operand load on start, then one shift-add step per cycle while busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         prod_q   <= '0;
      end else if (busy_q) begin
         prod_q   <= prod_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU: single-cycle ops complete one cycle after accept, MUL runs
// on the iterative multiplier. Results are held until the consumer takes them.
module pipelined_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fxn,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             o_flow,
   output logic             c_out,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned Msb = WIDTH - 1;

   state_e               state_q, state_d;
   logic                 accept;
   logic                 is_mul;
   logic                 mul_start;
   logic                 mul_done;
   logic [2*WIDTH-1:0]   mul_product;

   logic [WIDTH-1:0]     out_q, hi_q, acc_q;
   logic                 oflow_q, cout_q, zero_q, neg_q;

   logic [WIDTH:0]       sum, diff, acc_sum;
   logic [WIDTH-1:0]     res, acc_d;
   logic                 res_c, res_o;

   assign accept    = in_valid && in_ready;
   assign is_mul    = (fxn_e'(fxn) == FxnMul);
   assign mul_start = accept && is_mul;

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (input_a),
      .b       (input_b),
      .done    (mul_done),
      .product (mul_product)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = is_mul ? StExec : StDone;
         StExec:  if (mul_done) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
   end

   // Single-cycle result and flags, evaluated on the live inputs at accept
   always_comb begin
      sum     = {1'b0, input_a} + {1'b0, input_b};
      diff    = {1'b0, input_a} - {1'b0, input_b};
      acc_sum = {1'b0, acc_q} + {1'b0, input_a};
      res     = '0;
      res_c   = 1'b0;
      res_o   = 1'b0;
      acc_d   = acc_q;
      unique case (fxn_e'(fxn))
         FxnAdd: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_o = (input_a[Msb] == input_b[Msb]) && (sum[Msb] != input_a[Msb]);
         end
         FxnSub: begin
            res   = diff[WIDTH-1:0];
            res_c = ~diff[WIDTH];  // borrow-out inverted: 1 means a >= b
            res_o = (input_a[Msb] != input_b[Msb]) && (diff[Msb] != input_a[Msb]);
         end
         FxnAnd: res = input_a & input_b;
         FxnOr:  res = input_a | input_b;
         FxnXor: res = input_a ^ input_b;
         FxnSlt: res = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
         FxnMul: res = '0;  // produced by the multiplier instead
         FxnAcc: begin
            res   = acc_sum[WIDTH-1:0];
            res_c = acc_sum[WIDTH];
            res_o = (acc_q[Msb] == input_a[Msb]) && (acc_sum[Msb] != acc_q[Msb]);
            acc_d = acc_sum[WIDTH-1:0];
         end
         default: res = '0;
      endcase
   end

   // Result registers: loaded at accept (single-cycle ops) or at multiplier finish
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         hi_q    <= '0;
         acc_q   <= '0;
         oflow_q <= 1'b0;
         cout_q  <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else if (accept && !is_mul) begin
         out_q   <= res;
         hi_q    <= '0;
         acc_q   <= acc_d;
         oflow_q <= res_o;
         cout_q  <= res_c;
         zero_q  <= (res == '0);
         neg_q   <= res[Msb];
      end else if ((state_q == StExec) && mul_done) begin
         out_q   <= mul_product[WIDTH-1:0];
         hi_q    <= mul_product[2*WIDTH-1:WIDTH];
         oflow_q <= |mul_product[2*WIDTH-1:WIDTH];
         cout_q  <= 1'b0;
         zero_q  <= (mul_product[WIDTH-1:0] == '0);
         neg_q   <= mul_product[Msb];
      end
   end

   assign out    = out_q;
   assign out_hi = hi_q;
   assign o_flow = oflow_q;
   assign c_out  = cout_q;
   assign zero   = zero_q;
   assign neg    = neg_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed corner cases, randomized ops
// against an arithmetic reference model, and a reset-during-MUL scenario.
module tb_pipelined_alu;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   fxn = '0;
   logic [W-1:0] input_a = '0;
   logic [W-1:0] input_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out, out_hi;
   logic         o_flow, c_out, zero, neg;

   int n_tests = 0;
   int n_fail  = 0;
   int m_acc   = 0;

   pipelined_alu #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fxn       (fxn),
      .input_a   (input_a),
      .input_b   (input_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_hi    (out_hi),
      .o_flow    (o_flow),
      .c_out     (c_out),
      .zero      (zero),
      .neg       (neg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   function automatic int out_of_range(input int s);
      return ((s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)))) ? 1 : 0;
   endfunction

   // Reference model; updates m_acc for ACC ops
   task automatic model(input int f, input int a, input int b,
                        output int r, output int hi, output int c, output int o);
      int mask;
      int p;
      mask = (1 << W) - 1;
      hi = 0; c = 0; o = 0; r = 0;
      case (f)
         0: begin
            r = (a + b) & mask; c = (a + b) >> W;
            o = out_of_range(to_signed(a) + to_signed(b));
         end
         1: begin
            r = (a - b) & mask; c = (a >= b) ? 1 : 0;
            o = out_of_range(to_signed(a) - to_signed(b));
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (to_signed(a) < to_signed(b)) ? 1 : 0;
         6: begin
            p = a * b; r = p & mask; hi = p >> W; o = (hi != 0) ? 1 : 0;
         end
         default: begin
            r = (m_acc + a) & mask; c = (m_acc + a) >> W;
            o = out_of_range(to_signed(m_acc) + to_signed(a));
            m_acc = r;
         end
      endcase
   endtask

   // Issue one op (caller is at a negedge), wait for the result, check it,
   // optionally stall the consumer for hold cycles, then retire it.
   task automatic run_op(input int f, input int a, input int b, input int hold);
      int r, hi, c, o, z, n, lat, snap;
      model(f, a, b, r, hi, c, o);
      z = (r == 0) ? 1 : 0;
      n = (r >> (W - 1)) & 1;
      snap = (((r << W) | hi) << 4) | (o << 3) | (c << 2) | (z << 1) | n;
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; fxn = 3'(f); input_a = W'(a); input_b = W'(b);
      @(negedge clk);
      in_valid = 1'b0;
      fxn = 3'($urandom); input_a = W'($urandom); input_b = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin
         check("in_ready_busy", in_ready, 0);
         @(negedge clk);
         lat++;
      end
      check($sformatf("latency_f%0d", f), lat, (f == 6) ? W + 1 : 1);
      check($sformatf("out_f%0d_%0d_%0d", f, a, b), out, r);
      check("out_hi", out_hi, hi);
      check("c_out", c_out, c);
      check("o_flow", o_flow, o);
      check("zero", zero, z);
      check("neg", neg, n);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; fxn = 3'($urandom);
         input_a = W'($urandom); input_b = W'($urandom);
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_stable", {out, out_hi, o_flow, c_out, zero, neg}, snap);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("retire_valid", out_valid, 0);
      check("retire_in_ready", in_ready, 1);
   endtask

   initial begin
      int seen;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", {out, out_hi, o_flow, c_out, zero, neg}, 0);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);
      // First accept lands on the first edge after release
      run_op(0, 63, 1, 0);
      run_op(0, 31, 1, 0);
      run_op(6, 63, 63, 0);
      for (int i = 0; i < 4; i++) run_op(7, 20, $urandom_range(0, 63), 0);
      run_op(1, 0, 1, 0);
      run_op(5, 63, 0, 0);
      run_op(2, 45, 27, 5);
      run_op(6, 0, 37, 2);
      for (int i = 0; i < 200; i++) begin
         run_op($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 3));
      end

      // Reset three cycles into a MUL discards it and clears the accumulator
      in_valid = 1'b1; fxn = 3'd6; input_a = 6'd63; input_b = 6'd63;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_outputs", {out, out_hi, o_flow, c_out, zero, neg}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 0;
      seen = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("no_stale_valid", seen, 0);
      run_op(0, 2, 3, 0);
      run_op(7, 9, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter WIDTH, default 6, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand/op presented.
REQ-005 in_ready  output  1  block can accept an op this cycle.
REQ-006 fxn  input  3  operation code (see REQ-012).
REQ-007 input_a, input_b  input  WIDTH  operands.
REQ-008 out_valid  output  1  result held and valid.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 out, out_hi  output  WIDTH each  result; out_hi is the upper product half for MUL, else 0.
REQ-011 o_flow, c_out, zero, neg  output  1 each  overflow, carry, result==0, out[WIDTH-1].

Function
REQ-012 fxn encoding: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SLT (signed a<b gives 1, else 0), 6 MUL (unsigned, 2*WIDTH product), 7 ACC (acc <= acc + input_a, out = new acc).
REQ-013 FSM states IDLE, EXEC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept = in_valid & in_ready at a rising edge; fxn and operands SHALL be captured then; later input changes SHALL have no effect on that op.
REQ-015 Non-MUL ops: IDLE -> DONE on accept; out_valid SHALL be 1 the cycle after accept (latency 1).
REQ-016 MUL: IDLE -> EXEC on accept; shift-add for exactly WIDTH cycles; EXEC -> DONE, so out_valid rises WIDTH+1 cycles after accept.
REQ-017 DONE: outputs SHALL remain stable until out_valid & out_ready at an edge, then DONE -> IDLE; out_valid deasserts the following cycle.
REQ-018 Arithmetic mod 2^WIDTH; ADD: c_out = unsigned carry, o_flow = signed overflow.
REQ-019 SUB: c_out = 1 when no borrow (a >= b unsigned), o_flow = signed overflow.
REQ-020 AND/OR/XOR/SLT: c_out = 0, o_flow = 0.
REQ-021 MUL: out = low product half, out_hi = high half, o_flow = (out_hi != 0), c_out = 0.
REQ-022 ACC: flags computed as ADD on (acc, input_a); acc wraps mod 2^WIDTH.
REQ-023 acc SHALL change only on ACC ops; zero and neg SHALL derive from out only.
REQ-024 in_valid while not in IDLE SHALL be ignored (not queued).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready 1 (after release), out_valid 0, out/out_hi/acc 0, all flags 0.
REQ-026 Reset asserted mid-EXEC or in DONE SHALL discard the op; no out_valid for it after release.
REQ-027 First accept possible on the first rising edge with rst_n high.

Structure
REQ-028 Package alu_pkg SHALL hold the fxn encoding constants and FSM state encoding.
REQ-029 Iterative multiplier SHALL be sub-module alu_mul_seq (start, operands, done, 2*WIDTH product); all else in pipelined_alu.

Verification (WIDTH=6)
REQ-030 ADD 63+1 -> out 0, c_out 1, o_flow 0, zero 1; ADD 31+1 -> out 32, o_flow 1, neg 1.
REQ-031 MUL 63*63 -> out_hi 62, out 1, o_flow 1; out_valid exactly 7 cycles after accept; in_ready 0 throughout.
REQ-032 ACC input_a=20 four times -> out 20, 40, 60, 16 (last with c_out 1).
REQ-033 SUB 0-1 -> out 63, c_out 0, neg 1; SLT a=63 (-1), b=0 -> out 1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out and flags unchanged, in_ready 0, new in_valid ignored.
REQ-035 rst_n pulsed low 3 cycles into a MUL -> out_valid 0, acc 0; next ADD 2+3 -> out 5 at latency 1.
